// File: rtl/mr_scoreboard.sv
// Issue-stage register file with a per-register pending-write scoreboard, multiple
// writeback ports and a bounded in-flight count. Define MR_SB_BYPASS_EN to forward writebacks within the cycle.
module mr_scoreboard #(
    parameter int XLEN         = 32,
    parameter int NREGS        = 32,
    parameter int CNT_BITS     = 2,
    parameter int NUM_WB       = 2,
    parameter int MAX_INFLIGHT = 4,
    localparam int RSEL        = $clog2(NREGS),
    localparam int IFW         = $clog2(MAX_INFLIGHT + 1),
    localparam int RETW        = $clog2(NUM_WB + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [RSEL-1:0]        rs1_sel,
    input  logic [RSEL-1:0]        rs2_sel,
    input  logic [RSEL-1:0]        rd_sel,
    input  logic                   uses_rs1,
    input  logic                   uses_rs2,
    input  logic                   uses_rd,
    input  logic                   is_branch,
    input  logic                   issue,
    output logic                   ok_to_issue,
    output logic [XLEN-1:0]        rs1_data,
    output logic [XLEN-1:0]        rs2_data,
    input  logic [NUM_WB-1:0]      wb_valid,
    input  logic [NUM_WB*RSEL-1:0] wb_reg,
    input  logic [NUM_WB*XLEN-1:0] wb_val,
    input  logic                   jmp_done,
    output logic [IFW-1:0]         inflight,
    output logic [RETW-1:0]        insts_ret,
    output logic                   err
);
    localparam int CW = CNT_BITS + RETW + 1;
    localparam int IW = IFW + RETW + 1;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic [NREGS-1:0][XLEN-1:0]     rf_q, rf_d;
    logic [NREGS-1:0][CNT_BITS-1:0] pend_q, pend_d;
    logic [NREGS-1:0][RETW-1:0]     hits;
    logic [IFW-1:0]                 inflight_q, inflight_d;
    logic                           jmp_q, jmp_d, err_q, err_d;
    logic [RETW-1:0]                ret_cnt;
    logic                           byp1, byp2;
    logic [XLEN-1:0]                bv1, bv2;
    logic                           hazard, issue_ok;
    logic [CW-1:0]                  sum_t, hit_t;
    logic [IW-1:0]                  if_t;

    // Ascending port order makes the highest-index port win a shared destination.
    always_comb begin
        hits    = '0;
        ret_cnt = '0;
        rf_d    = rf_q;
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid[p]) begin
                ret_cnt = ret_cnt + RETW'(1);
                if (wb_reg[p*RSEL +: RSEL] != '0) begin
                    hits[wb_reg[p*RSEL +: RSEL]] = hits[wb_reg[p*RSEL +: RSEL]] + RETW'(1);
                    rf_d[wb_reg[p*RSEL +: RSEL]] = wb_val[p*XLEN +: XLEN];
                end
            end
        end
    end

`ifdef MR_SB_BYPASS_EN
    // Forward only when this cycle's writebacks drain every pending write to the source.
    always_comb begin
        bv1 = '0;
        bv2 = '0;
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid[p] && wb_reg[p*RSEL +: RSEL] == rs1_sel) bv1 = wb_val[p*XLEN +: XLEN];
            if (wb_valid[p] && wb_reg[p*RSEL +: RSEL] == rs2_sel) bv2 = wb_val[p*XLEN +: XLEN];
        end
        byp1 = !rst && rs1_sel != '0 && hits[rs1_sel] != '0 &&
               CW'(pend_q[rs1_sel]) == CW'(hits[rs1_sel]);
        byp2 = !rst && rs2_sel != '0 && hits[rs2_sel] != '0 &&
               CW'(pend_q[rs2_sel]) == CW'(hits[rs2_sel]);
    end
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
    assign bv1  = '0;
    assign bv2  = '0;
`endif

    assign hazard = (uses_rs1 && rs1_sel != '0 && pend_q[rs1_sel] != '0 && !byp1) ||
                    (uses_rs2 && rs2_sel != '0 && pend_q[rs2_sel] != '0 && !byp2) ||
                    (uses_rd && rd_sel != '0 && pend_q[rd_sel] == CNT_MAX) ||
                    jmp_q || (inflight_q == IFW'(MAX_INFLIGHT));

    assign ok_to_issue = !rst && !hazard;
    assign issue_ok    = issue && ok_to_issue;
    assign rs1_data    = (rst || rs1_sel == '0) ? '0 : (byp1 ? bv1 : rf_q[rs1_sel]);
    assign rs2_data    = (rst || rs2_sel == '0) ? '0 : (byp2 ? bv2 : rf_q[rs2_sel]);
    assign insts_ret   = ret_cnt;
    assign inflight    = inflight_q;
    assign err         = err_q;

    // A violating update leaves its own counter/flag untouched and raises err.
    always_comb begin
        err_d  = err_q | (issue && !ok_to_issue);
        pend_d = pend_q;
        sum_t  = '0;
        hit_t  = '0;
        for (int r = 0; r < NREGS; r++) begin
            sum_t = CW'(pend_q[r]) +
                    CW'(issue_ok && uses_rd && rd_sel != '0 && rd_sel == RSEL'(r));
            hit_t = CW'(hits[r]);
            if (hit_t > sum_t) err_d = 1'b1;
            else               pend_d[r] = CNT_BITS'(sum_t - hit_t);
        end

        jmp_d = jmp_q;
        if (jmp_done) begin
            if (!jmp_q) err_d = 1'b1;
            jmp_d = 1'b0;
        end
        if (issue_ok && is_branch) jmp_d = 1'b1;

        inflight_d = inflight_q;
        if_t       = IW'(inflight_q) + IW'(issue_ok);
        if (if_t < IW'(ret_cnt)) err_d = 1'b1;
        else                     inflight_d = IFW'(if_t - IW'(ret_cnt));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_q       <= '0;
            pend_q     <= '0;
            inflight_q <= '0;
            jmp_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rf_q       <= rf_d;
            pend_q     <= pend_d;
            inflight_q <= inflight_d;
            jmp_q      <= jmp_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_mr_scoreboard.sv
// Directed bench for mr_scoreboard with default parameters; expectations follow
// MR_SB_BYPASS_EN when it is defined for the build.
module tb_mr_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_sel, rs2_sel, rd_sel;
    logic        uses_rs1, uses_rs2, uses_rd, is_branch, issue, jmp_done;
    logic        ok_to_issue, err;
    logic [31:0] rs1_data, rs2_data;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_reg;
    logic [63:0] wb_val;
    logic [2:0]  inflight;
    logic [1:0]  insts_ret;

`ifdef MR_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    mr_scoreboard dut (
        .clk(clk), .rst(rst), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .rd_sel(rd_sel),
        .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .uses_rd(uses_rd),
        .is_branch(is_branch), .issue(issue), .ok_to_issue(ok_to_issue),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_valid(wb_valid),
        .wb_reg(wb_reg), .wb_val(wb_val), .jmp_done(jmp_done),
        .inflight(inflight), .insts_ret(insts_ret), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        rs1_sel = '0; rs2_sel = '0; rd_sel = '0;
        uses_rs1 = 0; uses_rs2 = 0; uses_rd = 0; is_branch = 0; issue = 0; jmp_done = 0;
        wb_valid = '0; wb_reg = '0; wb_val = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wbp(input int p, input logic [4:0] r, input logic [31:0] v);
        wb_valid[p]       = 1'b1;
        wb_reg[p*5 +: 5]  = r;
        wb_val[p*32 +: 32] = v;
    endtask

    task automatic iss_rd(input logic [4:0] r);
        clr();
        uses_rd = 1; rd_sel = r; issue = 1;
        step();
        clr();
    endtask

    task automatic do_rst();
        clr(); rst = 1; step(); rst = 0; #1;
    endtask

    initial begin
        clr(); rst = 1; rs1_sel = 5;
        #1;
        chk("rst_ok", ok_to_issue, 0);
        chk("rst_rs1", rs1_data, 0);
        step(); rst = 0; #1;
        chk("rel_ok", ok_to_issue, 1);
        chk("rel_err", err, 0);
        chk("rel_infl", inflight, 0);

        // RAW on x5, resolved by a port-0 writeback
        iss_rd(5);
        chk("t1_infl", inflight, 1);
        uses_rs1 = 1; rs1_sel = 5; #1;
        chk("t1_raw", ok_to_issue, 0);
        step();
        wbp(0, 5, 32'hDEADBEEF); #1;
        chk("t1_ret", insts_ret, 1);
        chk("t1_wb_ok", ok_to_issue, BYP);
        chk("t1_wb_dat", rs1_data, BYP ? 32'hDEADBEEF : 32'h0);
        step(); wb_valid = '0; #1;
        chk("t1_ok", ok_to_issue, 1);
        chk("t1_dat", rs1_data, 32'hDEADBEEF);
        chk("t1_infl0", inflight, 0);
        chk("t1_err", err, 0);

        // Saturate pend[3], force an illegal issue
        for (int i = 0; i < 3; i++) iss_rd(3);
        uses_rd = 1; rd_sel = 3; #1;
        chk("t2_full", ok_to_issue, 0);
        issue = 1; step(); clr(); #1;
        chk("t2_err", err, 1);
        chk("t2_infl", inflight, 3);
        uses_rs1 = 1; rs1_sel = 3;
        wbp(0, 3, 32'h1); wbp(1, 3, 32'h2);
        step(); wb_valid = '0; #1;
        chk("t2_pend1", ok_to_issue, 0);
        chk("t2_infl1", inflight, 1);
        wbp(0, 3, 32'h3);
        step(); wb_valid = '0; #1;
        chk("t2_pend0", ok_to_issue, 1);
        chk("t2_dat", rs1_data, 32'h3);
        chk("t2_infl0", inflight, 0);
        do_rst();

        // Issue x7 with two same-cycle retires to x7
        iss_rd(7); iss_rd(7);
        uses_rd = 1; rd_sel = 7; issue = 1;
        wbp(0, 7, 32'h11111111); wbp(1, 7, 32'h22222222); #1;
        chk("t3_ret", insts_ret, 2);
        chk("t3_ok", ok_to_issue, 1);
        step(); clr();
        uses_rs1 = 1; rs1_sel = 7; #1;
        chk("t3_win", rs1_data, 32'h22222222);
        chk("t3_pend1", ok_to_issue, 0);
        chk("t3_infl", inflight, 1);
        wbp(0, 7, 32'h33333333); #1;
        chk("t3_byp_ok", ok_to_issue, BYP);
        chk("t3_byp_dat", rs1_data, BYP ? 32'h33333333 : 32'h22222222);
        step(); wb_valid = '0; #1;
        chk("t3_ok2", ok_to_issue, 1);
        chk("t3_dat2", rs1_data, 32'h33333333);
        chk("t3_err", err, 0);
        chk("t3_infl0", inflight, 0);

        // Branch flag
        clr(); is_branch = 1; issue = 1; step(); clr(); #1;
        chk("t4_br_haz", ok_to_issue, 0);
        chk("t4_infl", inflight, 1);
        jmp_done = 1; #1;
        chk("t4_done_cyc", ok_to_issue, 0);
        step(); jmp_done = 0; #1;
        chk("t4_ok", ok_to_issue, 1);
        chk("t4_err0", err, 0);
        wbp(0, 0, 32'h0); step(); wb_valid = '0; #1;
        chk("t4_infl0", inflight, 0);
        jmp_done = 1; step(); jmp_done = 0; #1;
        chk("t4_err1", err, 1);
        do_rst();

        // In-flight limit with stores
        iss_rd(9);
        wbp(1, 9, 32'hA5A5A5A5); step(); clr();
        for (int i = 0; i < 4; i++) iss_rd(0);
        #1;
        chk("t5_infl4", inflight, 4);
        chk("t5_full", ok_to_issue, 0);
        wbp(0, 0, 32'hFFFFFFFF); rs2_sel = 9; #1;
        chk("t5_ret", insts_ret, 1);
        step(); wb_valid = '0; #1;
        chk("t5_infl3", inflight, 3);
        chk("t5_ok", ok_to_issue, 1);
        chk("t5_rf9", rs2_data, 32'hA5A5A5A5);
        chk("t5_rs1z", rs1_data, 0);
        chk("t5_err0", err, 0);
        clr(); wb_valid = 2'b11; step();
        wb_valid = 2'b01; step(); clr(); #1;
        chk("t5_drain", inflight, 0);
        chk("t5_err0b", err, 0);
        wb_valid = 2'b01; step(); clr(); #1;
        chk("t5_uf_err", err, 1);
        chk("t5_uf_infl", inflight, 0);

        // Reset mid-stream with pend[2]=2, jmp set, err set
        iss_rd(2); iss_rd(2);
        is_branch = 1; issue = 1; step(); clr();
        rst = 1; uses_rd = 1; rd_sel = 2; issue = 1; #1;
        chk("t6_rst_ok", ok_to_issue, 0);
        step(); rst = 0; clr();
        uses_rs1 = 1; rs1_sel = 2; rs2_sel = 9; #1;
        chk("t6_ok", ok_to_issue, 1);
        chk("t6_infl", inflight, 0);
        chk("t6_err", err, 0);
        chk("t6_rf", rs2_data, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
